// File: rtl/radclk_pkg.sv
// Shared types and constants for the SPI time-of-day receive path.
package radclk_pkg;

  typedef struct packed {
    logic [4:0] hour;
    logic [5:0] minute;
    logic [5:0] second;
  } time_t;

  localparam int unsigned FRAME_BITS     = 32;
  localparam logic [7:0]  HEADER_DEFAULT = 8'hA5;
  localparam int unsigned MAX_HOUR       = 24;
  localparam int unsigned MAX_MIN        = 60;

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK} state_e;

  function automatic logic frame_ok(input logic [31:0] f, input logic [7:0] hdr);
    return (f[31:24] == hdr) && (f[23:16] < 8'(MAX_HOUR)) &&
           (f[15:8] < 8'(MAX_MIN)) && (f[7:0] < 8'(MAX_MIN));
  endfunction

endpackage

// File: rtl/spi_bit_sampler.sv
// Brings sclk/sdi into the local clock domain and flags each sclk rising edge.
module spi_bit_sampler (
  input  logic clk,
  input  logic reset,
  input  logic sclk,
  input  logic sdi,
  output logic rise,
  output logic data_bit
);

  logic sclk_meta_q, sclk_meta_d;
  logic sclk_s_q,    sclk_s_d;
  logic sclk_dly_q,  sclk_dly_d;
  logic sdi_meta_q,  sdi_meta_d;
  logic sdi_s_q,     sdi_s_d;

  always_comb begin
    sclk_meta_d = sclk;
    sclk_s_d    = sclk_meta_q;
    sclk_dly_d  = sclk_s_q;
    sdi_meta_d  = sdi;
    sdi_s_d     = sdi_meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_meta_q <= 1'b0;
      sclk_s_q    <= 1'b0;
      sclk_dly_q  <= 1'b0;
      sdi_meta_q  <= 1'b0;
      sdi_s_q     <= 1'b0;
    end else begin
      sclk_meta_q <= sclk_meta_d;
      sclk_s_q    <= sclk_s_d;
      sclk_dly_q  <= sclk_dly_d;
      sdi_meta_q  <= sdi_meta_d;
      sdi_s_q     <= sdi_s_d;
    end
  end

  assign rise     = sclk_s_q & ~sclk_dly_q;
  assign data_bit = sdi_s_q;

endmodule

// File: rtl/spi_time_receiver.sv
// Receives 32-bit time frames over SPI, validates them, and publishes the
// latest good time on the vsync falling edge so the display never tears.
module spi_time_receiver
  import radclk_pkg::*;
#(
  parameter int unsigned TIMEOUT = 2500,
  parameter logic [7:0]  HEADER  = HEADER_DEFAULT,
  parameter int unsigned ERRW    = 8
) (
  input  logic            vgaclk,
  input  logic            reset,
  input  logic            sclk,
  input  logic            sdi,
  input  logic            vsync,
  output logic [4:0]      hour,
  output logic [5:0]      minute,
  output logic [5:0]      second,
  output logic            time_valid,
  output logic            new_time,
  output logic            frame_err,
  output logic [ERRW-1:0] err_cnt
);

  localparam int unsigned TW = $clog2(TIMEOUT);

  logic rise, data_bit;

  spi_bit_sampler u_sampler (
    .clk      (vgaclk),
    .reset    (reset),
    .sclk     (sclk),
    .sdi      (sdi),
    .rise     (rise),
    .data_bit (data_bit)
  );

  state_e          state_q,      state_d;
  logic [31:0]     shreg_q,      shreg_d;
  logic [5:0]      bit_cnt_q,    bit_cnt_d;
  logic [TW-1:0]   to_cnt_q,     to_cnt_d;
  time_t           staging_q,    staging_d;
  logic            pending_q,    pending_d;
  time_t           disp_q,       disp_d;
  logic            valid_q,      valid_d;
  logic            new_time_q,   new_time_d;
  logic            frame_err_q,  frame_err_d;
  logic [ERRW-1:0] err_cnt_q,    err_cnt_d;
  logic            vsync_q,      vsync_d;

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    bit_cnt_d   = bit_cnt_q;
    to_cnt_d    = to_cnt_q;
    staging_d   = staging_q;
    pending_d   = pending_q;
    disp_d      = disp_q;
    valid_d     = valid_q;
    new_time_d  = 1'b0;
    frame_err_d = 1'b0;
    err_cnt_d   = err_cnt_q;
    vsync_d     = vsync;

    // Latch evaluates before CHECK so a coincident good frame waits for the next vsync.
    if (vsync_q && !vsync && pending_q) begin
      disp_d     = staging_q;
      pending_d  = 1'b0;
      valid_d    = 1'b1;
      new_time_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        bit_cnt_d = '0;
        to_cnt_d  = '0;
        if (rise) begin
          shreg_d   = {shreg_q[30:0], data_bit};
          bit_cnt_d = 6'd1;
          state_d   = SHIFT;
        end
      end
      SHIFT: begin
        if (rise) begin
          shreg_d   = {shreg_q[30:0], data_bit};
          bit_cnt_d = bit_cnt_q + 6'd1;
          to_cnt_d  = '0;
          if (bit_cnt_q == 6'(FRAME_BITS - 1)) state_d = CHECK;
        end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
          state_d     = IDLE;
          bit_cnt_d   = '0;
          to_cnt_d    = '0;
          frame_err_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
      end
      CHECK: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
        to_cnt_d  = '0;
        if (frame_ok(shreg_q, HEADER)) begin
          staging_d = '{hour: shreg_q[20:16], minute: shreg_q[13:8], second: shreg_q[5:0]};
          pending_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
        if (rise) begin
          shreg_d   = {shreg_q[30:0], data_bit};
          bit_cnt_d = 6'd1;
          state_d   = SHIFT;
        end
      end
      default: state_d = IDLE;
    endcase

    if (frame_err_d && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge vgaclk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      to_cnt_q    <= '0;
      staging_q   <= '0;
      pending_q   <= 1'b0;
      disp_q      <= '0;
      valid_q     <= 1'b0;
      new_time_q  <= 1'b0;
      frame_err_q <= 1'b0;
      err_cnt_q   <= '0;
      vsync_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      to_cnt_q    <= to_cnt_d;
      staging_q   <= staging_d;
      pending_q   <= pending_d;
      disp_q      <= disp_d;
      valid_q     <= valid_d;
      new_time_q  <= new_time_d;
      frame_err_q <= frame_err_d;
      err_cnt_q   <= err_cnt_d;
      vsync_q     <= vsync_d;
    end
  end

  assign hour       = disp_q.hour;
  assign minute     = disp_q.minute;
  assign second     = disp_q.second;
  assign time_valid = valid_q;
  assign new_time   = new_time_q;
  assign frame_err  = frame_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_spi_time_receiver.sv
// Directed and randomized frame traffic against a frame-level model of the receiver.
module tb_spi_time_receiver;

  logic       vgaclk = 1'b0;
  logic       reset  = 1'b1;
  logic       sclk   = 1'b0;
  logic       sdi    = 1'b0;
  logic       vsync  = 1'b1;
  logic [4:0] hour;
  logic [5:0] minute, second;
  logic       time_valid, new_time, frame_err;
  logic [7:0] err_cnt;

  always #5 vgaclk = ~vgaclk;

  spi_time_receiver #(.TIMEOUT(2500), .HEADER(8'hA5), .ERRW(8)) dut (
    .vgaclk     (vgaclk),
    .reset      (reset),
    .sclk       (sclk),
    .sdi        (sdi),
    .vsync      (vsync),
    .hour       (hour),
    .minute     (minute),
    .second     (second),
    .time_valid (time_valid),
    .new_time   (new_time),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt)
  );

  int unsigned total = 0, passed = 0;
  int unsigned nt_seen = 0, fe_seen = 0, exp_nt = 0, exp_fe = 0;

  // Frame-level model: words in, displayed word out.
  logic        m_pend  = 1'b0;
  logic [31:0] m_stage = '0;
  logic [31:0] m_disp  = '0;
  logic        m_valid = 1'b0;
  int unsigned m_err   = 0;

  always @(negedge vgaclk) begin
    if (!reset) begin
      if (new_time === 1'b1) nt_seen++;
      if (frame_err === 1'b1) fe_seen++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge vgaclk);
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
  endtask

  function automatic logic good(input logic [31:0] w);
    int unsigned h, mi, s;
    h = w[23:16]; mi = w[15:8]; s = w[7:0];
    return (w[31:24] == 8'hA5) && h <= 23 && mi <= 59 && s <= 59;
  endfunction

  task automatic model_frame(input logic [31:0] w);
    if (good(w)) begin
      m_pend  = 1'b1;
      m_stage = w;
    end else begin
      exp_fe++;
      if (m_err < 255) m_err++;
    end
  endtask

  task automatic model_vsync();
    if (m_pend) begin
      m_disp  = m_stage;
      m_valid = 1'b1;
      m_pend  = 1'b0;
      exp_nt++;
    end
  endtask

  task automatic send(input logic [31:0] w, input int nbits, input int half);
    for (int i = 31; i >= 32 - nbits; i--) begin
      sdi = w[i];
      tick(half);
      sclk = 1'b1;
      tick(half);
      sclk = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".hour"},   32'(hour),       32'(m_disp[23:16]));
    chk({tag, ".minute"}, 32'(minute),     32'(m_disp[15:8]));
    chk({tag, ".second"}, 32'(second),     32'(m_disp[7:0]));
    chk({tag, ".valid"},  32'(time_valid), 32'(m_valid));
    chk({tag, ".errcnt"}, 32'(err_cnt),    m_err);
    chk({tag, ".ntcnt"},  nt_seen,         exp_nt);
    chk({tag, ".fecnt"},  fe_seen,         exp_fe);
  endtask

  task automatic do_frame(input logic [31:0] w, input int half);
    send(w, 32, half);
    tick(8);
    model_frame(w);
    chk("frame.errcnt", 32'(err_cnt), m_err);
  endtask

  task automatic do_vsync(input string tag);
    logic upd;
    upd = m_pend;
    vsync = 1'b0;
    tick(1);
    chk({tag, ".newtime"}, 32'(new_time), 32'(upd));
    model_vsync();
    tick(3);
    vsync = 1'b1;
    tick(2);
    check_all(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    m_pend = 1'b0; m_stage = '0; m_disp = '0; m_valid = 1'b0; m_err = 0;
    tick(2);
  endtask

  initial begin
    logic [31:0] w, b;
    tick(3);
    reset = 1'b0;
    tick(2);
    check_all("reset");

    // Good frame held back until vsync falls.
    do_frame(32'hA50C1E2D, 8);
    tick(20);
    check_all("no_vsync");
    do_vsync("first");

    // Range and header rejects leave the display untouched.
    do_frame(32'hA5183B00, 8);
    check_all("bad_hour");
    do_frame(32'h5A010203, 8);
    check_all("bad_hdr");

    // Partial frame aborted by timeout, then a clean frame realigns.
    send(32'hA5112233, 20, 8);
    tick(2600);
    exp_fe++; m_err++;
    check_all("timeout");
    do_frame(32'hA5010203, 8);
    do_vsync("after_to");

    // Two frames before one vsync: latest wins, single update.
    do_frame(32'hA5010101, 6);
    do_frame(32'hA5020202, 6);
    do_vsync("latest");
    do_vsync("no_pend");

    // Reset in the middle of a frame.
    send(32'hA5090909, 17, 4);
    do_reset();
    check_all("mid_reset");
    do_frame(32'hA5030405, 4);
    do_vsync("post_reset");

    // Last bit's CHECK cycle coincides with the vsync fall.
    do_frame(32'hA5070809, 4);
    b = 32'hA50A0B0C;
    send(b, 31, 4);
    sdi = b[0];
    tick(4);
    sclk = 1'b1;
    tick(3);
    vsync = 1'b0;
    tick(1);
    chk("align.newtime", 32'(new_time), 32'd1);
    model_vsync();
    model_frame(b);
    tick(3);
    sclk = 1'b0;
    tick(2);
    vsync = 1'b1;
    tick(3);
    check_all("align");
    do_vsync("align_next");

    // Randomized frames with random sclk rate and vsync placement.
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(3, 0) != 0)
        w = {8'hA5, 8'($urandom_range(23, 0)), 8'($urandom_range(59, 0)), 8'($urandom_range(59, 0))};
      else
        w = $urandom;
      do_frame(w, int'($urandom_range(8, 3)));
      if ($urandom_range(1, 0) == 1) do_vsync("rand");
    end
    do_vsync("rand_end");

    // Enough bad frames to saturate the error counter.
    for (int i = 0; i < 265; i++) begin
      w = {8'h5A, 24'($urandom)};
      send(w, 32, 3);
      tick(4);
      model_frame(w);
    end
    tick(8);
    check_all("saturate");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
